// File: rtl/hazard_unit_if.sv
// Pipeline hazard bus: register numbers, stage qualifiers and the hazard unit's
// forward/stall/flush/status outputs. The slave modport is the hazard unit's view.
interface hazard_unit_if;
  logic [3:0]  RA1_d;
  logic [3:0]  RA2_d;
  logic [3:0]  RA1_e;
  logic [3:0]  RA2_e;
  logic [3:0]  WA3_e;
  logic [3:0]  WA3_m;
  logic [3:0]  WA3_w;
  logic        RegWrite_mp;
  logic        RegWrite_w;
  logic        MemtoReg_ep;
  logic        PCSrc_dp;
  logic        PCSrc_ep;
  logic        PCSrc_mp;
  logic        PCSrc_w;
  logic        branchtakene;
  logic        blwritep;
  logic [1:0]  ForwardA_e;
  logic [1:0]  ForwardB_e;
  logic        Stall_f;
  logic        Stall_d;
  logic        Flush_d;
  logic        Flush_e;
  logic [1:0]  hz_state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output RA1_d, RA2_d, RA1_e, RA2_e, WA3_e, WA3_m, WA3_w,
    output RegWrite_mp, RegWrite_w, MemtoReg_ep,
    output PCSrc_dp, PCSrc_ep, PCSrc_mp, PCSrc_w, branchtakene, blwritep,
    input  ForwardA_e, ForwardB_e, Stall_f, Stall_d, Flush_d, Flush_e,
    input  hz_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  RA1_d, RA2_d, RA1_e, RA2_e, WA3_e, WA3_m, WA3_w,
    input  RegWrite_mp, RegWrite_w, MemtoReg_ep,
    input  PCSrc_dp, PCSrc_ep, PCSrc_mp, PCSrc_w, branchtakene, blwritep,
    output ForwardA_e, ForwardB_e, Stall_f, Stall_d, Flush_d, Flush_e,
    output hz_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use stall, PC-write flush
// and a status FSM. Define HAZARD_PERF_EN to build the saturating stall/flush counters.
module hazard_unit (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    PCWAIT  = 2'b10,
    BRFLUSH = 2'b11
  } hz_state_t;

  logic      r_bl_m;
  logic      r_bl_w;
  hz_state_t r_state;

  logic w_ldstall;
  logic w_pc_pend;
  logic w_stall_f;
  logic w_stall_d;
  logic w_flush_d;
  logic w_flush_e;

  // One identical forwarding selector per Execute source operand.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic [3:0] w_ra;
      logic [1:0] w_sel;

      assign w_ra = (gi == 0) ? bus.RA1_e : bus.RA2_e;

      always_comb begin
        w_sel = 2'b00;
        if (w_ra == 4'd15) begin
          w_sel = 2'b00;
        end else if (r_bl_m && (w_ra == 4'd14)) begin
          w_sel = 2'b11;
        end else if (bus.RegWrite_mp && (w_ra == bus.WA3_m)) begin
          w_sel = 2'b10;
        end else if ((bus.RegWrite_w || (r_bl_w && (w_ra == 4'd14))) &&
                     (w_ra == bus.WA3_w)) begin
          w_sel = 2'b01;
        end
      end
    end
  endgenerate

  assign bus.ForwardA_e = g_fwd[0].w_sel;
  assign bus.ForwardB_e = g_fwd[1].w_sel;

  assign w_ldstall = bus.MemtoReg_ep && (bus.WA3_e != 4'd15) &&
                     ((bus.RA1_d == bus.WA3_e) || (bus.RA2_d == bus.WA3_e));
  assign w_pc_pend = bus.PCSrc_dp || bus.PCSrc_ep || bus.PCSrc_mp;

  assign w_stall_f = w_ldstall || w_pc_pend;
  assign w_stall_d = w_ldstall;
  assign w_flush_d = w_pc_pend || bus.PCSrc_w || bus.branchtakene;
  assign w_flush_e = w_ldstall || bus.branchtakene;

  assign bus.Stall_f  = w_stall_f;
  assign bus.Stall_d  = w_stall_d;
  assign bus.Flush_d  = w_flush_d;
  assign bus.Flush_e  = w_flush_e;
  assign bus.hz_state = r_state;

  // A flushed Execute stage must not carry its link write into Memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bl_m  <= 1'b0;
      r_bl_w  <= 1'b0;
      r_state <= RUN;
    end else begin
      r_bl_m <= bus.blwritep && !w_flush_e;
      r_bl_w <= r_bl_m;
      if (bus.branchtakene) begin
        r_state <= BRFLUSH;
      end else if (w_pc_pend) begin
        r_state <= PCWAIT;
      end else if (w_ldstall) begin
        r_state <= LDSTALL;
      end else begin
        r_state <= RUN;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'h0000;
      r_flush_cnt <= 16'h0000;
    end else begin
      if (w_stall_d && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_flush_e && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cnt = 16'h0000;
  assign bus.flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_unit;

  logic clk;
  logic reset;

  hazard_unit_if hif();

  hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [3:0]  ctl;   // {Stall_f, Stall_d, Flush_d, Flush_e}
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;
  logic [15:0] m_sc;
  logic [15:0] m_fc;

  task automatic idle();
    hif.RA1_d = 4'd0;  hif.RA2_d = 4'd0;
    hif.RA1_e = 4'd0;  hif.RA2_e = 4'd0;
    hif.WA3_e = 4'd0;  hif.WA3_m = 4'd0;  hif.WA3_w = 4'd0;
    hif.RegWrite_mp = 1'b0;  hif.RegWrite_w = 1'b0;
    hif.MemtoReg_ep = 1'b0;
    hif.PCSrc_dp = 1'b0;  hif.PCSrc_ep = 1'b0;
    hif.PCSrc_mp = 1'b0;  hif.PCSrc_w  = 1'b0;
    hif.branchtakene = 1'b0;  hif.blwritep = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_use();
    hif.MemtoReg_ep = 1'b1;
    hif.WA3_e = 4'd2;
    hif.RA2_d = 4'd2;
  endtask

  // Counters are expected at their running totals; they only exist with HAZARD_PERF_EN.
  task automatic expect_v(input string name, input logic [1:0] fa, input logic [1:0] fb,
                          input logic [3:0] ctl, input logic [1:0] st);
    exp_t e;
    e.name = name;
    e.fa   = fa;
    e.fb   = fb;
    e.ctl  = ctl;
    e.st   = st;
`ifdef HAZARD_PERF_EN
    e.sc = reset ? 16'h0000 : m_sc;
    e.fc = reset ? 16'h0000 : m_fc;
    if (reset) begin
      m_sc = 16'h0000;
      m_fc = 16'h0000;
    end else begin
      if (ctl[2] && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (ctl[0] && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end
`else
    e.sc = 16'h0000;
    e.fc = 16'h0000;
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    logic [3:0] act_ctl;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_ctl = {hif.Stall_f, hif.Stall_d, hif.Flush_d, hif.Flush_e};
        n_vec++;
        if (hif.ForwardA_e !== e.fa || hif.ForwardB_e !== e.fb || act_ctl !== e.ctl ||
            hif.hz_state !== e.st || hif.stall_cnt !== e.sc || hif.flush_cnt !== e.fc) begin
          n_err++;
          $display("FAIL %s: got fa=%b fb=%b ctl=%b st=%b sc=%h fc=%h, want fa=%b fb=%b ctl=%b st=%b sc=%h fc=%h",
                   e.name, hif.ForwardA_e, hif.ForwardB_e, act_ctl, hif.hz_state,
                   hif.stall_cnt, hif.flush_cnt, e.fa, e.fb, e.ctl, e.st, e.sc, e.fc);
        end else begin
          $display("vec %s ok: fa=%b fb=%b ctl=%b st=%b sc=%h fc=%h", e.name,
                   hif.ForwardA_e, hif.ForwardB_e, act_ctl, hif.hz_state,
                   hif.stall_cnt, hif.flush_cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    m_sc  = 16'h0000;
    m_fc  = 16'h0000;
    reset = 1'b1;
    idle();
    #1;
    expect_v("reset", 2'b00, 2'b00, 4'b0000, 2'b00);

    nxt(); reset = 1'b0;
    expect_v("idle", 2'b00, 2'b00, 4'b0000, 2'b00);

    nxt();
    hif.RA1_e = 4'd3; hif.WA3_m = 4'd3; hif.RegWrite_mp = 1'b1;
    hif.WA3_w = 4'd3; hif.RegWrite_w = 1'b1; hif.RA2_e = 4'd5;
    expect_v("fwd_mem_over_wb", 2'b10, 2'b00, 4'b0000, 2'b00);

    nxt();
    hif.RA1_e = 4'd4; hif.RA2_e = 4'd3; hif.WA3_m = 4'd3;
    hif.WA3_w = 4'd3; hif.RegWrite_w = 1'b1;
    expect_v("fwd_wb", 2'b00, 2'b01, 4'b0000, 2'b00);

    nxt();
    hif.RA1_e = 4'd15; hif.RA2_e = 4'd15; hif.WA3_m = 4'd15; hif.RegWrite_mp = 1'b1;
    hif.WA3_w = 4'd15; hif.RegWrite_w = 1'b1;
    expect_v("fwd_pc_never", 2'b00, 2'b00, 4'b0000, 2'b00);

    nxt(); load_use();
    expect_v("ldstall", 2'b00, 2'b00, 4'b1101, 2'b00);
    nxt();
    expect_v("ldstall_bubble", 2'b00, 2'b00, 4'b0000, 2'b01);
    nxt();
    expect_v("ldstall_done", 2'b00, 2'b00, 4'b0000, 2'b00);

    nxt();
    hif.MemtoReg_ep = 1'b1; hif.WA3_e = 4'd15; hif.RA1_d = 4'd15;
    expect_v("ldstall_r15", 2'b00, 2'b00, 4'b0000, 2'b00);

    nxt(); hif.PCSrc_dp = 1'b1;
    expect_v("pc_d", 2'b00, 2'b00, 4'b1010, 2'b00);
    nxt(); hif.PCSrc_ep = 1'b1;
    expect_v("pc_e", 2'b00, 2'b00, 4'b1010, 2'b10);
    nxt(); hif.PCSrc_mp = 1'b1;
    expect_v("pc_m", 2'b00, 2'b00, 4'b1010, 2'b10);
    nxt(); hif.PCSrc_w = 1'b1;
    expect_v("pc_w", 2'b00, 2'b00, 4'b0010, 2'b10);
    nxt();
    expect_v("pc_done", 2'b00, 2'b00, 4'b0000, 2'b00);

    nxt(); hif.blwritep = 1'b1;
    expect_v("bl_exec", 2'b00, 2'b00, 4'b0000, 2'b00);
    nxt(); hif.RA1_e = 4'd14; hif.RA2_e = 4'd2;
    expect_v("bl_fwd_mem", 2'b11, 2'b00, 4'b0000, 2'b00);
    nxt();
    hif.RA1_e = 4'd14; hif.RA2_e = 4'd14; hif.WA3_w = 4'd14; hif.WA3_m = 4'd14;
    expect_v("bl_fwd_wb", 2'b01, 2'b01, 4'b0000, 2'b00);
    nxt(); hif.RA1_e = 4'd14; hif.WA3_w = 4'd14;
    expect_v("bl_gone", 2'b00, 2'b00, 4'b0000, 2'b00);

    nxt(); hif.blwritep = 1'b1; hif.branchtakene = 1'b1;
    expect_v("bl_flushed_br", 2'b00, 2'b00, 4'b0011, 2'b00);
    nxt(); hif.RA1_e = 4'd14;
    expect_v("bl_killed", 2'b00, 2'b00, 4'b0000, 2'b11);
    nxt();
    expect_v("br_done", 2'b00, 2'b00, 4'b0000, 2'b00);

    nxt();
    hif.branchtakene = 1'b1; hif.MemtoReg_ep = 1'b1; hif.WA3_e = 4'd2; hif.RA1_d = 4'd2;
    hif.RA1_e = 4'd15; hif.WA3_m = 4'd15; hif.RegWrite_mp = 1'b1;
    expect_v("br_and_ldstall", 2'b00, 2'b00, 4'b1111, 2'b00);
    nxt();
    expect_v("br_state", 2'b00, 2'b00, 4'b0000, 2'b11);
    nxt();
    expect_v("br_state_exit", 2'b00, 2'b00, 4'b0000, 2'b00);

    nxt(); load_use();
    expect_v("pre_reset_stall", 2'b00, 2'b00, 4'b1101, 2'b00);
    nxt(); load_use();
    #1 reset = 1'b1;
    expect_v("reset_mid_stall", 2'b00, 2'b00, 4'b1101, 2'b00);
    nxt(); reset = 1'b0;
    expect_v("after_reset", 2'b00, 2'b00, 4'b0000, 2'b00);

    nxt();
    expect_v("pre_sat", 2'b00, 2'b00, 4'b0000, 2'b00);
    nxt();
`ifdef HAZARD_PERF_EN
    force dut.r_stall_cnt = 16'hFFFE;
    #1;
    release dut.r_stall_cnt;
    m_sc = 16'hFFFE;
`endif
    load_use();
    expect_v("sat_stall1", 2'b00, 2'b00, 4'b1101, 2'b00);
    nxt(); load_use();
    expect_v("sat_stall2", 2'b00, 2'b00, 4'b1101, 2'b01);
    nxt(); load_use();
    expect_v("sat_hold", 2'b00, 2'b00, 4'b1101, 2'b01);
    nxt();
    #1 reset = 1'b1;
    expect_v("cnt_async_reset", 2'b00, 2'b00, 4'b0000, 2'b00);
    nxt(); reset = 1'b0;
    expect_v("final_idle", 2'b00, 2'b00, 4'b0000, 2'b00);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
